if_id_pipe_stage: RTL and testbench

- Parametrised IF→ID pipeline stage register. It is the successor to the fixed 32-bit stall/flush register.
- Adds a valid/ready handshake on both sides and a 2-entry skid buffer, so upstream stalls are registered rather than combinational.
- Adds a configurable flush bubble and saturating stall/flush event counters.
- Sits between instruction fetch and decode. The hazard unit drives stall and flush.

---
 rtl/if_id_pipe_stage.sv | 140 ++++++++++++++
 tb/tb_if_id_pipe_stage.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe_stage.sv
// IF->ID pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush bubble insertion and saturating stall/flush event counters.
module if_id_pipe_stage #(
  parameter int unsigned            ADDR_W       = 32,
  parameter int unsigned            INST_W       = 32,
  parameter logic [INST_W-1:0]      NOP_INST     = INST_W'(32'h0000_0013),
  parameter bit                     FLUSH_BUBBLE = 1'b1,
  parameter int unsigned            CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic [INST_W-1:0] in_inst_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic [INST_W-1:0] out_inst_o,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } entry_t;

  // Encoding is {out_valid, skid_valid}; 2'b01 is unreachable by construction.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam entry_t BUBBLE = '{addr: '0, inst: NOP_INST};

  state_e             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic   out_valid;
  logic   skid_valid;
  logic   acc_in;
  logic   acc_out;
  entry_t in_entry;

  assign out_valid  = state_q[1];
  assign skid_valid = state_q[0];
  assign in_entry   = '{addr: in_addr_i, inst: in_inst_i};
  assign acc_in     = in_valid_i & ~skid_valid;
  assign acc_out    = out_valid & out_ready_i & ~stall_i;

  // in_ready comes straight from a register bit: no path from out_ready/stall.
  assign in_ready_o  = ~skid_valid;
  assign out_valid_o = out_valid;
  assign out_addr_o  = main_q.addr;
  assign out_inst_o  = main_q.inst;
  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= BUBBLE;
      skid_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next-state and datapath; flush overrides stall and any acceptance.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = FLUSH_BUBBLE ? ONE : EMPTY;
      main_d  = BUBBLE;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc_in) begin
            state_d = ONE;
            main_d  = in_entry;
          end
        end
        ONE: begin
          if (acc_in && acc_out) begin
            main_d = in_entry;
          end else if (acc_in) begin
            state_d = FULL;
            skid_d  = in_entry;
          end else if (acc_out) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (acc_out) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // Saturating event counters; clear beats increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (cnt_clr_i) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (out_valid && !acc_out && !flush_i && (stall_cnt_q != '1)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (flush_i && (flush_cnt_q != '1)) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe_stage.sv
// Directed bench for if_id_pipe_stage: default config (a), FLUSH_BUBBLE=0 (b)
// and CNT_W=2 (c), all driven by the same stimulus.
module tb_if_id_pipe_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready, stall, flush, cnt_clr;
  logic [31:0] in_addr, in_inst;

  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid, c_in_ready, c_out_valid;
  logic [31:0] a_out_addr, a_out_inst, b_out_addr, b_out_inst, c_out_addr, c_out_inst;
  logic [15:0] a_stall_cnt, a_flush_cnt, b_stall_cnt, b_flush_cnt;
  logic [1:0]  c_stall_cnt, c_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_pipe_stage u_a (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(a_in_ready),
    .in_addr_i(in_addr), .in_inst_i(in_inst), .out_valid_o(a_out_valid),
    .out_ready_i(out_ready), .out_addr_o(a_out_addr), .out_inst_o(a_out_inst),
    .stall_i(stall), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .stall_cnt_o(a_stall_cnt), .flush_cnt_o(a_flush_cnt)
  );

  if_id_pipe_stage #(.FLUSH_BUBBLE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(b_in_ready),
    .in_addr_i(in_addr), .in_inst_i(in_inst), .out_valid_o(b_out_valid),
    .out_ready_i(out_ready), .out_addr_o(b_out_addr), .out_inst_o(b_out_inst),
    .stall_i(stall), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .stall_cnt_o(b_stall_cnt), .flush_cnt_o(b_flush_cnt)
  );

  if_id_pipe_stage #(.CNT_W(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(c_in_ready),
    .in_addr_i(in_addr), .in_inst_i(in_inst), .out_valid_o(c_out_valid),
    .out_ready_i(out_ready), .out_addr_o(c_out_addr), .out_inst_o(c_out_inst),
    .stall_i(stall), .flush_i(flush), .cnt_clr_i(cnt_clr),
    .stall_cnt_o(c_stall_cnt), .flush_cnt_o(c_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] sat_exp [6];
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3; sat_exp[5] = 2'd3;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0;
    flush = 1'b0; cnt_clr = 1'b0; in_addr = '0; in_inst = '0;
    #12;
    // 1: reset state and first transfer
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_out_inst",  64'(a_out_inst), 64'h13);
    chk("rst_out_addr",  64'(a_out_addr), 64'h0);
    chk("rst_in_ready",  64'(a_in_ready), 64'd1);
    chk("rst_stall_cnt", 64'(a_stall_cnt), 64'd0);
    chk("rst_flush_cnt", 64'(a_flush_cnt), 64'd0);
    rst_n = 1'b1; in_valid = 1'b1; in_addr = 32'h100; in_inst = 32'h0050_0093; out_ready = 1'b1;
    tick();
    chk("t1_out_valid", 64'(a_out_valid), 64'd1);
    chk("t1_out_addr",  64'(a_out_addr), 64'h100);
    chk("t1_out_inst",  64'(a_out_inst), 64'h0050_0093);
    in_valid = 1'b0;
    tick();
    chk("t1_drained", 64'(a_out_valid), 64'd0);

    // 2: skid fill and drain
    in_valid = 1'b1; in_addr = 32'h0; in_inst = 32'h1; out_ready = 1'b0;
    tick();
    chk("t2_one_valid", 64'(a_out_valid), 64'd1);
    chk("t2_one_addr",  64'(a_out_addr), 64'h0);
    chk("t2_one_ready", 64'(a_in_ready), 64'd1);
    in_addr = 32'h4; in_inst = 32'h2;
    tick();
    chk("t2_full_ready", 64'(a_in_ready), 64'd0);
    chk("t2_full_addr",  64'(a_out_addr), 64'h0);
    in_addr = 32'h8; in_inst = 32'h3;
    tick();
    chk("t2_hold_ready", 64'(a_in_ready), 64'd0);
    chk("t2_hold_addr",  64'(a_out_addr), 64'h0);
    chk("t2_stall_cnt",  64'(a_stall_cnt), 64'd2);
    out_ready = 1'b1;
    tick();
    chk("t2_drain1_addr",  64'(a_out_addr), 64'h4);
    chk("t2_drain1_inst",  64'(a_out_inst), 64'h2);
    chk("t2_drain1_ready", 64'(a_in_ready), 64'd1);
    tick();
    chk("t2_drain2_addr",  64'(a_out_addr), 64'h8);
    chk("t2_drain2_valid", 64'(a_out_valid), 64'd1);
    in_valid = 1'b0;
    tick();
    chk("t2_empty_valid", 64'(a_out_valid), 64'd0);
    chk("t2_empty_addr",  64'(a_out_addr), 64'h8);
    chk("t2_stall_keep",  64'(a_stall_cnt), 64'd2);

    // 3: stall hold in ONE
    cnt_clr = 1'b1; in_valid = 1'b1; in_addr = 32'h20; in_inst = 32'h20;
    tick();
    chk("t3_clr_cnt", 64'(a_stall_cnt), 64'd0);
    chk("t3_addr",    64'(a_out_addr), 64'h20);
    cnt_clr = 1'b0; in_valid = 1'b0; stall = 1'b1;
    tick();
    chk("t3_stall1_cnt", 64'(a_stall_cnt), 64'd1);
    tick();
    tick();
    chk("t3_stall3_cnt",   64'(a_stall_cnt), 64'd3);
    chk("t3_stall3_addr",  64'(a_out_addr), 64'h20);
    chk("t3_stall3_valid", 64'(a_out_valid), 64'd1);
    stall = 1'b0;
    tick();
    chk("t3_consumed", 64'(a_out_valid), 64'd0);
    chk("t3_cnt_keep", 64'(a_stall_cnt), 64'd3);

    // 4: flush in FULL with stall and in_valid asserted
    in_valid = 1'b1; in_addr = 32'h40; in_inst = 32'h40; out_ready = 1'b0;
    tick();
    in_addr = 32'h44; in_inst = 32'h44;
    tick();
    chk("t4_full_ready", 64'(a_in_ready), 64'd0);
    chk("t4_b_full_ready", 64'(b_in_ready), 64'd0);
    flush = 1'b1; stall = 1'b1; out_ready = 1'b1; in_addr = 32'h48; in_inst = 32'h48;
    tick();
    chk("t4_a_valid",     64'(a_out_valid), 64'd1);
    chk("t4_a_addr",      64'(a_out_addr), 64'h0);
    chk("t4_a_inst",      64'(a_out_inst), 64'h13);
    chk("t4_a_ready",     64'(a_in_ready), 64'd1);
    chk("t4_a_flush_cnt", 64'(a_flush_cnt), 64'd1);
    chk("t4_a_stall_cnt", 64'(a_stall_cnt), 64'd4);
    chk("t4_b_valid",     64'(b_out_valid), 64'd0);
    chk("t4_b_addr",      64'(b_out_addr), 64'h0);
    chk("t4_b_inst",      64'(b_out_inst), 64'h13);
    chk("t4_b_ready",     64'(b_in_ready), 64'd1);
    tick();
    chk("t4_drop_addr",   64'(a_out_addr), 64'h0);
    chk("t4_drop_b",      64'(b_out_valid), 64'd0);
    chk("t4_flush_cnt2",  64'(a_flush_cnt), 64'd2);
    flush = 1'b0; stall = 1'b0; in_valid = 1'b0;
    tick();
    chk("t4_bubble_gone", 64'(a_out_valid), 64'd0);
    chk("t4_b_still_empty", 64'(b_out_valid), 64'd0);

    // 5: 2-bit counter saturation and clear
    cnt_clr = 1'b1; in_valid = 1'b1; in_addr = 32'h60; in_inst = 32'h60; out_ready = 1'b0;
    tick();
    chk("t5_clr_stall", 64'(c_stall_cnt), 64'd0);
    chk("t5_clr_flush", 64'(c_flush_cnt), 64'd0);
    cnt_clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t5_sat_%0d", i), 64'(c_stall_cnt), 64'(sat_exp[i]));
    end
    cnt_clr = 1'b1;
    tick();
    chk("t5_clr_c", 64'(c_stall_cnt), 64'd0);
    chk("t5_clr_a", 64'(a_stall_cnt), 64'd0);
    cnt_clr = 1'b0;
    tick();
    chk("t5_after_clr", 64'(c_stall_cnt), 64'd1);

    // 6: async reset while FULL
    in_valid = 1'b1; in_addr = 32'h64; in_inst = 32'h64;
    tick();
    chk("t6_full_ready", 64'(a_in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", 64'(a_out_valid), 64'd0);
    chk("t6_async_ready", 64'(a_in_ready), 64'd1);
    chk("t6_async_inst",  64'(a_out_inst), 64'h13);
    chk("t6_async_cnt",   64'(a_stall_cnt), 64'd0);
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("t6_no_stale1", 64'(a_out_valid), 64'd0);
    tick();
    chk("t6_no_stale2", 64'(a_out_valid), 64'd0);
    chk("t6_ready",     64'(a_in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
